// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - wash/rinse/[drain]/spin sequencer with pause, abort and done handshake
// Optional feature macro: DRAIN_PHASE_EN inserts a fixed 3 s DRAIN phase between RINSE and SPIN.
// Ports: clk, rst (async, active-low); start/pause/abort/ack one-cycle pulses; mode[1:0] sampled on start;
//        phase[2:0], remain[7:0] seconds left, busy, paused, done, st_light[7:0] registered status lights.
module wash_sequencer #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int T_WASH_S  = 10,
    parameter int T_WASH_M  = 20,
    parameter int T_WASH_L  = 30,
    parameter int T_RINSE_S = 5,
    parameter int T_RINSE_M = 10,
    parameter int T_RINSE_L = 15,
    parameter int T_SPIN_S  = 5,
    parameter int T_SPIN_M  = 5,
    parameter int T_SPIN_L  = 10,
    parameter int T_DRY     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       pause,
    input  logic       abort,
    input  logic       ack,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic       busy,
    output logic       paused,
    output logic       done,
    output logic [7:0] st_light
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam int T_DRAIN = 3;

    if (T_WASH_S > 255 || T_WASH_M > 255 || T_WASH_L > 255 ||
        T_RINSE_S > 255 || T_RINSE_M > 255 || T_RINSE_L > 255 ||
        T_SPIN_S > 255 || T_SPIN_M > 255 || T_SPIN_L > 255 ||
        T_DRY > 255 || TICK_DIV < 1) begin : g_bad_param
        $error("wash_sequencer: durations must be <= 255 and TICK_DIV >= 1");
    end

    // State codes double as the phase output encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WASH  = 3'd1,
        S_RINSE = 3'd2,
        S_SPIN  = 3'd3,
        S_DONE  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t        state, state_d, nxt;
    logic [7:0]    remain_d;
    logic          paused_d;
    logic [PW-1:0] pre, pre_d;
    logic [1:0]    mode_q, mode_d;
    logic          blink, blink_d;
    logic [PW-1:0] bcnt, bcnt_d;
    logic          tick;
    logic [7:0]    lights_d;

    function automatic logic [7:0] dur(input state_t s, input logic [1:0] m);
        logic [7:0] d;
        d = 8'd0;
        case (s)
            S_WASH:  case (m)
                         2'd0:    d = 8'(T_WASH_S);
                         2'd1:    d = 8'(T_WASH_M);
                         2'd2:    d = 8'(T_WASH_L);
                         default: d = 8'd0;
                     endcase
            S_RINSE: case (m)
                         2'd0:    d = 8'(T_RINSE_S);
                         2'd1:    d = 8'(T_RINSE_M);
                         2'd2:    d = 8'(T_RINSE_L);
                         default: d = 8'd0;
                     endcase
            S_SPIN:  case (m)
                         2'd0:    d = 8'(T_SPIN_S);
                         2'd1:    d = 8'(T_SPIN_M);
                         2'd2:    d = 8'(T_SPIN_L);
                         default: d = 8'(T_DRY);
                     endcase
`ifdef DRAIN_PHASE_EN
            S_DRAIN: d = (m == 2'd3) ? 8'd0 : 8'(T_DRAIN);
`endif
            default: d = 8'd0;
        endcase
        return d;
    endfunction

    function automatic state_t succ(input state_t s);
        state_t n;
        case (s)
            S_IDLE:  n = S_WASH;
            S_WASH:  n = S_RINSE;
`ifdef DRAIN_PHASE_EN
            S_RINSE: n = S_DRAIN;
`else
            S_RINSE: n = S_SPIN;
`endif
            S_DRAIN: n = S_SPIN;
            default: n = S_DONE;
        endcase
        return n;
    endfunction

    // Next phase with a non-zero duration; zero-length phases are skipped in one transition.
    function automatic state_t next_run(input state_t s, input logic [1:0] m);
        state_t n;
        n = succ(s);
        for (int i = 0; i < 4; i++) begin
            if (n != S_DONE && dur(n, m) == 8'd0) n = succ(n);
        end
        return n;
    endfunction

    always_comb begin
        state_d  = state;
        remain_d = remain;
        paused_d = paused;
        pre_d    = pre;
        mode_d   = mode_q;
        blink_d  = blink;
        bcnt_d   = bcnt;
        tick     = 1'b0;
        nxt      = next_run(state, mode_q);
        if (abort && state != S_IDLE) begin
            state_d  = S_IDLE;
            remain_d = 8'd0;
            paused_d = 1'b0;
            pre_d    = '0;
            blink_d  = 1'b0;
            bcnt_d   = '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mode_d   = mode;
                    state_d  = next_run(S_IDLE, mode);
                    remain_d = dur(next_run(S_IDLE, mode), mode);
                    pre_d    = '0;
                end
                S_DONE: if (ack) begin
                    state_d  = S_IDLE;
                    remain_d = 8'd0;
                end
                default: begin
                    tick = !paused && (pre == PRE_MAX);
                    if (!paused) pre_d = tick ? '0 : pre + PW'(1);
                    // Blink has its own divider so the phase prescaler stays frozen while paused.
                    if (paused) begin
                        bcnt_d = (bcnt == PRE_MAX) ? '0 : bcnt + PW'(1);
                        if (bcnt == PRE_MAX) blink_d = ~blink;
                    end
                    // A pause pulse on a tick cycle consumes that tick without acting on it.
                    if (pause) begin
                        paused_d = ~paused;
                        blink_d  = 1'b1;
                        bcnt_d   = '0;
                    end else if (tick) begin
                        if (remain > 8'd1) begin
                            remain_d = remain - 8'd1;
                        end else begin
                            state_d  = nxt;
                            remain_d = dur(nxt, mode_q);
                        end
                    end
                end
            endcase
        end

        lights_d    = 8'd0;
        lights_d[0] = (state_d == S_WASH);
        lights_d[1] = (state_d == S_RINSE);
        lights_d[2] = (state_d == S_SPIN);
`ifdef DRAIN_PHASE_EN
        lights_d[3] = (state_d == S_DRAIN);
`endif
        lights_d[5] = paused_d & blink_d;
        lights_d[6] = (state_d == S_DONE);
        lights_d[7] = (state_d == S_WASH) || (state_d == S_RINSE) ||
                      (state_d == S_SPIN) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            remain   <= 8'd0;
            paused   <= 1'b0;
            pre      <= '0;
            mode_q   <= 2'b00;
            blink    <= 1'b0;
            bcnt     <= '0;
            st_light <= 8'd0;
        end else begin
            state    <= state_d;
            remain   <= remain_d;
            paused   <= paused_d;
            pre      <= pre_d;
            mode_q   <= mode_d;
            blink    <= blink_d;
            bcnt     <= bcnt_d;
            st_light <= lights_d;
        end
    end

    assign phase = state;
    assign busy  = (state == S_WASH) || (state == S_RINSE) || (state == S_SPIN) || (state == S_DRAIN);
    assign done  = (state == S_DONE);
endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - scoreboard bench for wash_sequencer with a list-driven phase model
module tb_wash_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, pause = 1'b0, abort = 1'b0, ack = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] phase;
    logic [7:0] remain;
    logic       busy, paused, done;
    logic [7:0] st_light;

    wash_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .pause(pause), .abort(abort), .ack(ack),
        .phase(phase), .remain(remain), .busy(busy), .paused(paused), .done(done), .st_light(st_light)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int wash_cycles = 0;
    int blink_toggles = 0;
    logic [22:0] sb[$];

    // Reference model: phase order as a list, durations from the mode table.
    int  seq[$];
    int  m_phase = 0, m_remain = 0, m_pre = 0, m_mode = 0;
    bit  m_paused = 0;

    function automatic int dur(int ph, int md);
        int tw[4] = '{10, 20, 30, 0};
        int tr[4] = '{5, 10, 15, 0};
        int ts[4] = '{5, 5, 10, 10};
        case (ph)
            1: return tw[md];
            2: return tr[md];
            3: return ts[md];
            5: return (md == 3) ? 0 : 3;
            default: return 0;
        endcase
    endfunction

    function automatic int advance(int ph, int md);
        int idx = -1;
        foreach (seq[j]) if (seq[j] == ph) idx = j;
        for (int j = idx + 1; j < seq.size(); j++)
            if (seq[j] == 4 || dur(seq[j], md) > 0) return seq[j];
        return 4;
    endfunction

    function automatic void model_step(bit s, int md, bit p, bit a, bit k);
        bit tk;
        if (a && m_phase != 0) begin
            m_phase = 0; m_remain = 0; m_paused = 0; m_pre = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                m_mode = md; m_phase = advance(0, md); m_remain = dur(m_phase, md); m_pre = 0;
            end
        end else if (m_phase == 4) begin
            if (k) begin m_phase = 0; m_remain = 0; end
        end else begin
            tk = !m_paused && m_pre == TD - 1;
            if (!m_paused) m_pre = (m_pre + 1) % TD;
            if (p) m_paused = !m_paused;
            else if (tk) begin
                if (m_remain > 1) m_remain--;
                else begin m_phase = advance(m_phase, m_mode); m_remain = dur(m_phase, m_mode); end
            end
        end
    endfunction

    function automatic logic [22:0] pack_model();
        logic [7:0] l;
        bit b;
        b = (m_phase == 1 || m_phase == 2 || m_phase == 3 || m_phase == 5);
        l = {b, m_phase == 4, 1'b0, 1'b0, m_phase == 5, m_phase == 3, m_phase == 2, m_phase == 1};
        return {m_paused, 3'(m_phase), 8'(m_remain), b, m_paused, m_phase == 4, l};
    endfunction

    task automatic cycle(input bit s, input bit p, input bit a, input bit k, input logic [1:0] md);
        @(negedge clk);
        start = s; pause = p; abort = a; ack = k; mode = md;
        model_step(s, int'(md), p, a, k);
        sb.push_back(pack_model());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 2'($urandom));
    endtask

    task automatic wait_phase(input int ph, input int limit);
        int n = 0;
        while (m_phase != ph && n < limit) begin idle(1); n++; end
        vectors++;
        if (m_phase != ph) begin
            miscompares++;
            $display("FAIL wait_phase timeout: model phase %0d, wanted %0d", m_phase, ph);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        start = 0; pause = 0; abort = 0; ack = 0;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({phase, remain, busy, paused, done, st_light} !== 22'd0) begin
            miscompares++;
            $display("FAIL async_reset: phase=%0d remain=%0d busy=%b paused=%b done=%b light=%h, required all 0",
                     phase, remain, busy, paused, done, st_light);
        end
        m_phase = 0; m_remain = 0; m_paused = 0; m_pre = 0; m_mode = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every cycle is an output beat; pop and compare whenever an expectation is pending.
    initial begin
        logic [22:0] e;
        logic [7:0]  lm;
        logic        prev_b5, prev_p;
        prev_b5 = 1'b0; prev_p = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (phase == 3'd1) wash_cycles++;
            if (paused && prev_p && st_light[5] != prev_b5) blink_toggles++;
            prev_b5 = st_light[5];
            prev_p  = paused;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                lm = e[22] ? (st_light & 8'hDF) : st_light;
                vectors++;
                if ({phase, remain, busy, paused, done, lm} !== e[21:0]) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: phase/remain/busy/paused/done/light = %0d/%0d/%b/%b/%b/%h, required %0d/%0d/%b/%b/%b/%h",
                             $time, phase, remain, busy, paused, done, lm,
                             e[21:19], e[18:11], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        int n;
        seq = '{1, 2, 3, 4};
`ifdef DRAIN_PHASE_EN
        seq = '{1, 2, 5, 3, 4};
`endif
        #12;
        vectors++;
        if ({phase, remain, busy, paused, done, st_light} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_state: phase=%0d remain=%0d busy=%b paused=%b done=%b light=%h, required all 0",
                     phase, remain, busy, paused, done, st_light);
        end
        @(negedge clk);
        rst = 1'b1;

        // Small cycle end to end, done held until ack.
        cycle(1, 0, 0, 0, 2'd0);
        wait_phase(4, 400);
        idle(5);
        cycle(1, 0, 0, 0, 2'd1);
        cycle(0, 0, 0, 1, 2'd0);
        idle(3);

        // Dry-only goes straight to SPIN.
        cycle(1, 0, 0, 0, 2'd3);
        wait_phase(4, 200);
        cycle(0, 0, 0, 1, 2'd0);
        idle(2);

        // Medium with a 50-cycle pause at remain 15 of WASH.
        wash_cycles = 0;
        cycle(1, 0, 0, 0, 2'd1);
        n = 0;
        while (!(m_phase == 1 && m_remain == 15 && m_pre != TD - 1) && n < 200) begin idle(1); n++; end
        cycle(0, 1, 0, 0, 2'd2);
        idle(49);
        cycle(0, 1, 0, 0, 2'd0);
        wait_phase(4, 600);
        vectors++;
        if (wash_cycles != 130) begin
            miscompares++;
            $display("FAIL wash_with_pause: %0d cycles in WASH, required 130", wash_cycles);
        end
        cycle(0, 0, 0, 1, 2'd0);
        idle(2);

        // Abort while paused in RINSE.
        cycle(1, 0, 0, 0, 2'd0);
        wait_phase(2, 200);
        idle(3);
        cycle(0, 1, 0, 0, 2'd0);
        idle(5);
        cycle(0, 0, 1, 0, 2'd0);
        idle(3);

        // Pause pulse landing on the final tick of WASH.
        cycle(1, 0, 0, 0, 2'd0);
        n = 0;
        while (!(m_phase == 1 && m_remain == 1 && m_pre == TD - 1 && !m_paused) && n < 200) begin idle(1); n++; end
        cycle(0, 1, 0, 0, 2'd0);
        idle(6);
        cycle(0, 1, 0, 0, 2'd0);
        idle(6);
        cycle(0, 0, 1, 0, 2'd0);
        idle(2);

        // Start while busy and mode changes after start are ignored.
        cycle(1, 0, 0, 0, 2'd0);
        idle(3);
        cycle(1, 0, 0, 0, 2'd2);
        wait_phase(4, 400);
        cycle(0, 0, 0, 1, 2'd3);
        idle(2);

        // Large cycle; async reset part-way through (DRAIN when present, else RINSE).
        cycle(1, 0, 0, 0, 2'd2);
`ifdef DRAIN_PHASE_EN
        wait_phase(5, 400);
`else
        wait_phase(2, 400);
`endif
        idle(5);
        async_reset();

        // Random pulses.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 16) == 0, ($urandom % 40) == 0, ($urandom % 150) == 0,
                  ($urandom % 8) == 0, 2'($urandom));
            if (i == 1500) async_reset();
        end

        idle(2);
        @(posedge clk);
        #3;
        vectors++;
        if (blink_toggles == 0) begin
            miscompares++;
            $display("FAIL pause_blink: bit5 toggled %0d times while paused, required > 0", blink_toggles);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
- Sequences the washing datapath once the pre phase has latched a mode: runs WASH, RINSE and SPIN sub-phases for mode-dependent durations.
- Supports pause/resume and abort.
- Raises a done handshake that the top-level FSM acknowledges before moving to billing.
- Drives the phase status lights and the seconds-remaining value for the 7-segment display path.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per 1 s tick; benches use 4.
- T_WASH_S/M/L, 10/20/30, wash seconds for small/medium/large.
- T_RINSE_S/M/L, 5/10/15, rinse seconds for small/medium/large.
- T_SPIN_S/M/L, 5/5/10, spin seconds for small/medium/large.
- T_DRY, 10, spin seconds in dry-only mode.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse (debounced centre button); starts a cycle
- mode  in  2  00 small, 01 medium, 10 large, 11 dry-only; sampled on start
- pause  in  1  one-cycle pulse; toggles pause
- abort  in  1  one-cycle pulse; returns to IDLE
- ack  in  1  one-cycle pulse; clears done
- phase  out  3  0 IDLE, 1 WASH, 2 RINSE, 3 SPIN, 4 DONE, 5 DRAIN
- remain  out  8  seconds left in the current phase
- busy  out  1  high in WASH/RINSE/DRAIN/SPIN, including while paused
- paused  out  1  pause flag
- done  out  1  high in DONE
- st_light  out  8  status lights

Behaviour:
- Reset (async, any state): phase=IDLE, remain=0, busy=0, paused=0, done=0, st_light=0, prescaler=0, latched mode=00.
- IDLE: start latches mode, then selects the first phase with non-zero duration and loads remain. Register update is on the same edge; outputs show the new phase 1 cycle after start. Prescaler clears on entry.
- Phase order: WASH -> RINSE -> [DRAIN] -> SPIN -> DONE.
  - Dry-only mode: WASH and RINSE durations are 0; start goes directly to SPIN with remain=T_DRY.
  - Any zero-duration phase is skipped in the same transition.
- Tick: prescaler counts 0..TICK_DIV-1 while busy and not paused; the tick fires when it wraps.
  - Tick with remain>1: remain decrements.
  - Tick with remain==1: advance to next phase, load its duration (remain=0 on DONE).
  - Each phase therefore lasts exactly N ticks.
- Pause:
  - In a busy state, the pause pulse toggles paused. Prescaler and remain freeze; phase holds.
  - Ignored in IDLE/DONE.
  - Resuming continues from the frozen prescaler value.
- DONE: done=1 until an ack pulse, then IDLE next edge. start in DONE is ignored.
- start while busy: ignored.
- abort in any non-IDLE state: IDLE next edge with all outputs at reset values.
- Simultaneous events: abort > pause > tick.
  - A pause pulse on a tick cycle sets paused; that tick is discarded (remain unchanged).
  - Mode changes after start have no effect.
- st_light:
  - bit0 WASH, bit1 RINSE, bit2 SPIN, bit3 DRAIN.
  - bit5 paused blinks: toggles each tick period; prescaler runs for blink only.
  - bit6 done, bit7 busy.
  - All registered.
- Widths: remain 8-bit unsigned; durations must be ≤255 (elaboration check).

Optional Feature:
- Macro DRAIN_PHASE_EN.
- Defined: DRAIN phase (code 5, 3 s fixed) inserted between RINSE and SPIN. Skipped in dry-only mode. Pausable like the other phases.
- Undefined: RINSE goes directly to SPIN; phase code 5 never appears; st_light bit3 tied 0.

Test Plan:
- TICK_DIV=4, mode=00, start pulse -> WASH remain=10.
  - RINSE at cycle 1+40 with remain=5, then SPIN remain=5, then DONE.
  - done stays high until ack; IDLE 1 cycle after ack.
- mode=11, start -> phase=SPIN, remain=10, no WASH/RINSE cycles; DONE after 40 cycles.
- mode=01, pause at remain=15 of WASH, hold 50 cycles -> remain stays 15, bit5 blinks.
  - pause again -> countdown resumes; total WASH time = 80 cycles + 50.
- abort during RINSE with paused=1 -> next edge phase=IDLE, busy=0, paused=0, remain=0.
- pause pulse on the tick cycle where remain==1 -> phase unchanged, paused=1, remain=1; resume -> advances after 4 cycles.
- DRAIN_PHASE_EN defined, mode=10 -> RINSE(15) -> DRAIN(3) -> SPIN(10).
  - Async rst low mid-DRAIN -> all outputs 0 immediately.
